vmu_mem_responder: RTL

Cache-side responder for the VMU vector memory request port. It accepts one line-wide vector request per cycle with a valid/ready handshake and services it against an internal line-organised data store. Stores are performed in place. Loads return a ticketed, fixed-latency response on the response port. It serves as the memory endpoint for VMU integration and as a scratchpad when no D-cache is attached.

---
 rtl/vmu_mem_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vmu_mem_responder.sv
// Line-organised memory endpoint for the VMU request port: stores update bytes
// in place, and loads return a masked, line-aligned response two cycles later.
module vmu_mem_responder #(
  parameter  int REQ_DATA_WIDTH = 256,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int MICROOP_WIDTH  = 5,
  parameter  int VECTOR_LANES   = 8,
  parameter  int MEM_DEPTH      = 256,
  localparam int LB             = REQ_DATA_WIDTH / 8,
  localparam int OFF_W          = $clog2(LB),
  localparam int IDX_W          = $clog2(MEM_DEPTH),
  localparam int SIZE_W         = $clog2(LB) + 1,
  localparam int TW             = $clog2(VECTOR_LANES) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]     mem_req_address_i,
  input  logic [MICROOP_WIDTH-1:0]  mem_req_microop_i,
  input  logic [SIZE_W-1:0]         mem_req_size_i,
  input  logic [TW-1:0]             mem_req_ticket_i,
  input  logic [REQ_DATA_WIDTH-1:0] mem_req_data_i,
  output logic                      cache_ready_o,
  output logic                      mem_resp_valid_o,
  output logic [TW-1:0]             mem_resp_ticket_o,
  output logic [SIZE_W-1:0]         mem_resp_size_o,
  output logic [REQ_DATA_WIDTH-1:0] mem_resp_data_o,
  input  logic                      stall_i,
  output logic                      busy_o
);

  typedef struct packed {
    logic                      valid;
    logic [TW-1:0]             ticket;
    logic [SIZE_W-1:0]         size;
    logic [REQ_DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t s1_q;
  stage_t s2_q;

  logic [REQ_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [OFF_W-1:0]          offset;
  logic [IDX_W-1:0]          index;
  logic [LB-1:0]             window;
  logic [REQ_DATA_WIDTH-1:0] line_masked;
  logic                      accept;
  logic                      load_fire;
  logic                      store_fire;

  assign offset = mem_req_address_i[OFF_W-1:0];
  assign index  = mem_req_address_i[OFF_W +: IDX_W];

  // Upper address bits alias onto the array and are deliberately dropped.
  if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_alias
    logic unused_upper;
    assign unused_upper = ^mem_req_address_i[ADDR_WIDTH-1:OFF_W+IDX_W];
  end

  assign cache_ready_o = ~stall_i;
  assign accept        = mem_req_valid_i & ~stall_i;
  assign load_fire     = accept & (mem_req_microop_i == '0);
  assign store_fire    = accept & (mem_req_microop_i != '0);

  // Byte window [offset, offset+size), clipped at the end of the line.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    window = '0;
    for (int b = 0; b < LB; b++) begin
      window[b] = (b >= int'(offset)) &&
                  (b <  int'(offset) + int'(mem_req_size_i));
    end
  end

  always_comb begin
    line_masked = '0;
    for (int b = 0; b < LB; b++) begin
      if (window[b]) begin
        line_masked[b*8 +: 8] = mem[index][b*8 +: 8];
      end
    end
  end

  // NOTE: the data array is intentionally left out of reset: clearing it would
  // need a per-line reset network, and its contents must survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (store_fire) begin
      for (int b = 0; b < LB; b++) begin
        if (window[b]) begin
          mem[index][b*8 +: 8] <= mem_req_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Payload fields only load alongside a valid entry, so the response outputs
  // keep their last values while no response is presented.
  // NOTE: sequential state uses non-blocking assignments so stage2 samples the
  // pre-edge stage1 contents, not the value being written this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (!stall_i) begin
      s1_q.valid <= load_fire;
      if (load_fire) begin
        s1_q.ticket <= mem_req_ticket_i;
        s1_q.size   <= mem_req_size_i;
        s1_q.data   <= line_masked;
      end
      s2_q.valid <= s1_q.valid;
      if (s1_q.valid) begin
        s2_q.ticket <= s1_q.ticket;
        s2_q.size   <= s1_q.size;
        s2_q.data   <= s1_q.data;
      end
    end
  end

  assign mem_resp_valid_o  = s2_q.valid & ~stall_i;
  assign mem_resp_ticket_o = s2_q.ticket;
  assign mem_resp_size_o   = s2_q.size;
  assign mem_resp_data_o   = s2_q.data;
  assign busy_o            = s1_q.valid | s2_q.valid;

endmodule
